// File: rtl/hififo_test_seq.sv
// PIO-configured traffic sequencer for the hififo channel pair: emits a counting
// pattern to tpc, loops fpc words back to tpc, or checks fpc words against a count.
module hififo_test_seq #(
    parameter logic [12:0] ADDR_BASE = 13'd16,
    parameter int          CNT_W     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pio_write_valid,
    input  logic [63:0]      pio_write_data,
    input  logic [12:0]      pio_address,
    output logic [63:0]      tpc_data,
    output logic             tpc_write,
    input  logic             tpc_ready,
    input  logic [63:0]      fpc_data,
    output logic             fpc_read,
    input  logic             fpc_empty,
    output logic             busy,
    output logic [CNT_W-1:0] words_done,
    output logic [CNT_W-1:0] error_count,
    output logic [3:0]       led
);

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_LOOP  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [12:0] ADDR_CTRL = ADDR_BASE;
    localparam logic [12:0] ADDR_LEN  = ADDR_BASE + 13'd1;
    localparam logic [12:0] ADDR_SEED = ADDR_BASE + 13'd2;
    localparam logic [12:0] ADDR_LED  = ADDR_BASE + 13'd3;

    state_t            state;
    mode_t             mode;
    logic [CNT_W-1:0]  length;
    logic [63:0]       seed;
    logic [63:0]       counter;

    logic sel_ctrl;
    logic sel_len;
    logic sel_seed;
    logic sel_led;
    logic at_length;
    logic active;
    logic count_issue;
    logic mismatch;

    assign sel_ctrl = pio_write_valid && (pio_address == ADDR_CTRL);
    assign sel_len  = pio_write_valid && (pio_address == ADDR_LEN);
    assign sel_seed = pio_write_valid && (pio_address == ADDR_SEED);
    assign sel_led  = pio_write_valid && (pio_address == ADDR_LED);

    // A CTRL write takes over the cycle, so no word moves while the run is being (re)started.
    assign at_length   = (length != '0) && (words_done == length);
    assign active      = (state == ST_RUN) && !sel_ctrl && !at_length;
    assign count_issue = active && (mode == MODE_COUNT) && tpc_ready;
    assign fpc_read    = active && !fpc_empty &&
                         (((mode == MODE_LOOP) && tpc_ready) || (mode == MODE_CHECK));
    assign mismatch    = (fpc_data != counter);
    assign busy        = (state == ST_RUN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            mode        <= MODE_IDLE;
            length      <= '0;
            seed        <= '0;
            counter     <= '0;
            led         <= 4'h5;
            tpc_write   <= 1'b0;
            tpc_data    <= '0;
            words_done  <= '0;
            error_count <= '0;
        end else begin
            tpc_write <= 1'b0;

            if (sel_len) begin
                length <= pio_write_data[CNT_W-1:0];
            end
            if (sel_seed) begin
                seed <= pio_write_data;
            end
            if (sel_led) begin
                led <= pio_write_data[3:0];
            end

            if (sel_ctrl) begin
                mode <= mode_t'(pio_write_data[1:0]);
                if (pio_write_data[1:0] != 2'd0) begin
                    counter     <= seed;
                    words_done  <= '0;
                    error_count <= '0;
                    state       <= ST_RUN;
                end else begin
                    state <= ST_IDLE;
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        if (at_length) begin
                            state <= ST_DONE;
                        end else begin
                            if (count_issue) begin
                                tpc_write  <= 1'b1;
                                tpc_data   <= counter;
                                counter    <= counter + 64'd1;
                                words_done <= words_done + 1'b1;
                            end
                            if (fpc_read) begin
                                words_done <= words_done + 1'b1;
                                if (mode == MODE_LOOP) begin
                                    tpc_write <= 1'b1;
                                    tpc_data  <= fpc_data;
                                end
                                if (mode == MODE_CHECK) begin
                                    // The expected value follows the sequence, not the received word.
                                    counter <= counter + 64'd1;
                                    if (mismatch && (error_count != '1)) begin
                                        error_count <= error_count + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hififo_test_seq.sv
// Directed-plus-random bench for hififo_test_seq with a queue-based fpc FIFO and a
// transaction-level model of the sequencer's counters and expected tpc traffic.
module tb_hififo_test_seq;

    logic        clock;
    logic        reset;
    logic        pio_write_valid;
    logic [63:0] pio_write_data;
    logic [12:0] pio_address;
    logic [63:0] tpc_data;
    logic        tpc_write;
    logic        tpc_ready;
    logic [63:0] fpc_data;
    logic        fpc_read;
    logic        fpc_empty;
    logic        busy;
    logic [31:0] words_done;
    logic [31:0] error_count;
    logic [3:0]  led;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] fq[$];
    logic [63:0] wlog[$];
    logic [63:0] pushed[$];

    bit          m_run;
    int          m_mode;
    logic [63:0] m_next;
    logic [63:0] m_seed;
    logic [31:0] m_len;
    logic [31:0] m_done;
    logic [31:0] m_err;
    logic [3:0]  m_led;

    hififo_test_seq #(.ADDR_BASE(13'd16), .CNT_W(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .pio_write_valid (pio_write_valid),
        .pio_write_data  (pio_write_data),
        .pio_address     (pio_address),
        .tpc_data        (tpc_data),
        .tpc_write       (tpc_write),
        .tpc_ready       (tpc_ready),
        .fpc_data        (fpc_data),
        .fpc_read        (fpc_read),
        .fpc_empty       (fpc_empty),
        .busy            (busy),
        .words_done      (words_done),
        .error_count     (error_count),
        .led             (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic refresh_fpc();
        fpc_empty = (fq.size() == 0);
        fpc_data  = fpc_empty ? 64'h0 : fq[0];
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_mode = 0;
        m_next = '0;
        m_seed = '0;
        m_len  = '0;
        m_done = '0;
        m_err  = '0;
        m_led  = 4'h5;
    endtask

    // One clock cycle: called just after a rising edge with inputs already driven.
    task automatic tick();
        bit          ctrl_now;
        bit          finished;
        bit          can;
        bit          exp_pop;
        bit          exp_wr;
        bit          popped;
        logic [63:0] exp_word;
        #3;
        ctrl_now = pio_write_valid && (pio_address == 13'd16);
        finished = (m_len != 0) && (m_done == m_len);
        can      = m_run && !ctrl_now && !finished;
        exp_pop  = can && !fpc_empty && ((m_mode == 2 && tpc_ready) || m_mode == 3);
        exp_wr   = can && ((m_mode == 1 && tpc_ready) || (m_mode == 2 && exp_pop));
        exp_word = (m_mode == 1) ? m_next : fpc_data;
        check("fpc_read", fpc_read, exp_pop);
        popped = (fpc_read === 1'b1) && !fpc_empty;

        if (exp_wr || exp_pop) m_done++;
        if (m_mode == 1 && exp_wr) m_next++;
        if (m_mode == 3 && exp_pop) begin
            if (fpc_data !== m_next && m_err != 32'hFFFF_FFFF) m_err++;
            m_next++;
        end
        if (m_run && finished && !ctrl_now) m_run = 0;
        if (pio_write_valid) begin
            case (pio_address)
                13'd16: begin
                    if (pio_write_data[1:0] != 2'd0) begin
                        m_mode = int'(pio_write_data[1:0]);
                        m_next = m_seed;
                        m_done = '0;
                        m_err  = '0;
                        m_run  = 1;
                    end else begin
                        m_mode = 0;
                        m_run  = 0;
                    end
                end
                13'd17: m_len  = pio_write_data[31:0];
                13'd18: m_seed = pio_write_data;
                13'd19: m_led  = pio_write_data[3:0];
                default: ;
            endcase
        end

        @(posedge clock);
        if (popped) void'(fq.pop_front());
        #1;
        pio_write_valid = 1'b0;
        refresh_fpc();
        if (tpc_write === 1'b1) wlog.push_back(tpc_data);
        check("tpc_write", tpc_write, exp_wr);
        if (exp_wr) check("tpc_data", tpc_data, exp_word);
        check("busy", busy, m_run);
        check("words_done", words_done, m_done);
        check("error_count", error_count, m_err);
        check("led", led, m_led);
    endtask

    task automatic pio(input logic [12:0] addr, input logic [63:0] data);
        pio_write_valid = 1'b1;
        pio_address     = addr;
        pio_write_data  = data;
        tick();
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, " tpc_write"}, tpc_write, 0);
        check({phase, " tpc_data"}, tpc_data, 0);
        check({phase, " fpc_read"}, fpc_read, 0);
        check({phase, " busy"}, busy, 0);
        check({phase, " words_done"}, words_done, 0);
        check({phase, " error_count"}, error_count, 0);
        check({phase, " led"}, led, 4'h5);
    endtask

    initial begin
        logic [63:0] s;
        int          qsize;

        reset           = 1'b0;
        pio_write_valid = 1'b0;
        pio_write_data  = '0;
        pio_address     = '0;
        tpc_ready       = 1'b0;
        refresh_fpc();
        model_reset();
        #1 reset = 1'b1;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Test 1: short COUNT run from 100.
        $display("[TB] COUNT length 4 from seed 100");
        pio(13'd19, 64'hA);
        pio(13'd17, 64'd4);
        pio(13'd18, 64'd100);
        tpc_ready = 1'b1;
        wlog.delete();
        pio(13'd16, 64'd1);
        repeat (7) tick();
        check("t1 count", wlog.size(), 4);
        for (int i = 0; i < 4; i++) check("t1 word", (i < wlog.size()) ? wlog[i] : 64'hX, 64'd100 + 64'(i));
        check("t1 busy", busy, 0);
        check("t1 words_done", words_done, 4);

        // Test 2: COUNT with alternating ready from a random seed.
        $display("[TB] COUNT with toggling tpc_ready");
        s = {$urandom, $urandom};
        pio(13'd18, s);
        pio(13'd17, 64'd6);
        wlog.delete();
        tpc_ready = 1'b0;
        pio(13'd16, 64'd1);
        for (int i = 0; i < 16; i++) begin
            tpc_ready = (i % 2 == 0);
            tick();
        end
        check("t2 count", wlog.size(), 6);
        for (int i = 0; i < 6; i++) check("t2 word", (i < wlog.size()) ? wlog[i] : 64'hX, s + 64'(i));

        // Test 5: counter wraps past all-ones.
        $display("[TB] COUNT wrap");
        tpc_ready = 1'b1;
        pio(13'd18, 64'hFFFF_FFFF_FFFF_FFFE);
        pio(13'd17, 64'd3);
        wlog.delete();
        pio(13'd16, 64'd1);
        repeat (6) tick();
        check("t5 count", wlog.size(), 3);
        check("t5 w0", (wlog.size() > 0) ? wlog[0] : 64'hX, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t5 w1", (wlog.size() > 1) ? wlog[1] : 64'hX, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t5 w2", (wlog.size() > 2) ? wlog[2] : 64'hX, 64'h0);

        // Test 3: unbounded LOOP, held off then released, then random traffic.
        $display("[TB] LOOP unbounded");
        tpc_ready = 1'b0;
        pio(13'd17, 64'd0);
        pio(13'd16, 64'd2);
        wlog.delete();
        pushed.delete();
        for (int i = 0; i < 3; i++) begin
            s = {$urandom, $urandom};
            fq.push_back(s);
            pushed.push_back(s);
        end
        refresh_fpc();
        repeat (3) tick();
        check("t3 held", fq.size(), 3);
        tpc_ready = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 40; i++) begin
            tpc_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                s = {$urandom, $urandom};
                fq.push_back(s);
                pushed.push_back(s);
                refresh_fpc();
            end
            tick();
        end
        tpc_ready = 1'b1;
        repeat (45) tick();
        check("t3 drained", fq.size(), 0);
        check("t3 count", wlog.size(), pushed.size());
        for (int i = 0; i < pushed.size(); i++) begin
            check("t3 order", (i < wlog.size()) ? wlog[i] : 64'hX, pushed[i]);
        end
        tpc_ready = 1'b0;
        pio(13'd16, 64'd0);
        check("t3 abort busy", busy, 0);

        // Test 4: CHECK with one bad word.
        $display("[TB] CHECK directed");
        fq = '{64'd0, 64'd1, 64'd7, 64'd3, 64'd4};
        refresh_fpc();
        pio(13'd18, 64'd0);
        pio(13'd17, 64'd5);
        pio(13'd16, 64'd3);
        repeat (8) tick();
        check("t4 errors", error_count, 1);
        check("t4 words_done", words_done, 5);
        check("t4 busy", busy, 0);
        check("t4 drained", fq.size(), 0);

        // CHECK with randomly corrupted words.
        $display("[TB] CHECK random");
        s = {$urandom, $urandom};
        pio(13'd18, s);
        pio(13'd17, 64'd8);
        for (int i = 0; i < 8; i++) begin
            fq.push_back(($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : s + 64'(i));
        end
        refresh_fpc();
        pio(13'd16, 64'd3);
        repeat (12) tick();
        check("t4r words_done", words_done, 8);

        // Test 6: reset in the middle of a LOOP run.
        $display("[TB] reset during LOOP");
        pio(13'd17, 64'd0);
        for (int i = 0; i < 4; i++) fq.push_back({$urandom, $urandom});
        refresh_fpc();
        tpc_ready = 1'b1;
        pio(13'd16, 64'd2);
        tick();
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("midrun");
        qsize = fq.size();
        repeat (2) begin
            @(negedge clock);
            check("reset fpc_read", fpc_read, 0);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        repeat (3) tick();
        check("t6 no pops", fq.size(), qsize);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
